cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter: WORDS, default 4, words per cache line; SHALL be a power of two in 2..16; OFF_W = log2(WORDS).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: cpu_req  in  1  CPU access request; sampled only when cpu_ready=1.
REQ-005 Port: cpu_wr  in  1  1=store, 0=load; captured with cpu_req.
REQ-006 Port: cpu_addr  in  32  byte address; captured with cpu_req.
REQ-007 Port: cpu_ready  out  1  controller idle and accepting a request.
REQ-008 Port: tag_hit  in  1  tag-compare result; valid only in LOOKUP.
REQ-009 Port: mem_rd  out  1  memory read request; held until mem_ack.
REQ-010 Port: mem_addr  out  32  word-aligned refill address.
REQ-011 Port: mem_ack  in  1  memory data valid on mem_data this cycle.
REQ-012 Port: mem_data  in  32  refill word from memory.
REQ-013 Port: memWrite  out  1  data-array write enable.
REQ-014 Port: miss  out  1  data-array source select: 1=refill data, 0=CPU data.
REQ-015 Port: word_dec  out  WORDS  one-hot word select; drives each data word's decode input.
REQ-016 Port: fill_data  out  32  registered refill word for the data array.
REQ-017 Port: tag_write  out  1  one-cycle pulse: install tag and valid bit.
REQ-018 Port: resp_valid  out  1  one-cycle pulse: access complete.
REQ-019 Port: hit_cnt, miss_cnt  out  16 each  saturating access-outcome counters.

Function
REQ-020 States SHALL be IDLE, LOOKUP, REFILL_REQ, REFILL_WR, TAG_WR, CPU_WR, DONE; encoding is free.
REQ-021 IDLE: cpu_ready=1; cpu_req=1 captures cpu_wr and cpu_addr, then moves to LOOKUP; in any other state cpu_ready=0 and cpu_req is ignored.
REQ-022 LOOKUP hit: hit_cnt+1; next state is CPU_WR if store, else DONE.
REQ-023 LOOKUP miss: miss_cnt+1; fill counter loaded with the requested word offset cpu_addr[OFF_W+1:2]; next state REFILL_REQ.
REQ-024 Counter saturation: hit_cnt and miss_cnt SHALL hold at 0xFFFF and never wrap.
REQ-025 REFILL_REQ: mem_rd=1; mem_addr = {cpu_addr[31:OFF_W+2], fill counter, 2'b00}; state holds while mem_ack=0.
REQ-026 REFILL_REQ with mem_ack=1: fill_data<=mem_data; next state REFILL_WR.
REQ-027 mem_ack in any state other than REFILL_REQ SHALL be ignored.
REQ-028 REFILL_WR, one cycle: memWrite=1, miss=1, word_dec one-hot of the fill counter; fill counter increments modulo WORDS (critical word first, wrap-around).
REQ-029 After REFILL_WR: next state is REFILL_REQ while fewer than WORDS words are written, else TAG_WR.
REQ-030 TAG_WR: tag_write=1 for one cycle; next state is CPU_WR if store, else DONE.
REQ-031 CPU_WR, one cycle: memWrite=1, miss=0, word_dec one-hot of the captured word offset; next state DONE.
REQ-032 DONE: resp_valid=1 for one cycle; next state IDLE.
REQ-033 Output defaults: outside the states named above, memWrite, miss, mem_rd, tag_write, resp_valid and word_dec SHALL be 0; word_dec SHALL never have more than one bit set.
REQ-034 Latency from the accept edge to the resp_valid cycle: load hit 2 cycles; store hit 3 cycles; miss 3 + sum over the words of (ack wait + 2) cycles, plus 1 more cycle for a store.

Reset
REQ-035 reset=0 SHALL immediately force IDLE. Reset values: cpu_ready=1; mem_rd, memWrite, miss, tag_write, resp_valid=0; word_dec=0; fill_data=0; mem_addr=0; hit_cnt=0; miss_cnt=0.
REQ-036 Reset during a refill SHALL abandon it: no tag_write pulse and no further memWrite until a new request arrives.

Verification
REQ-037 Load hit: load request to 0x100, tag_hit=1 -> resp_valid 2 cycles after accept, memWrite never 1, hit_cnt=1.
REQ-038 Store hit: store request to 0x10C, WORDS=4 -> exactly one memWrite cycle with miss=0 and word_dec=4'b1000, then resp_valid.
REQ-039 Load miss to 0x108, mem_ack held off 3 cycles per word -> mem_addr sequence 0x108, 0x10C, 0x100, 0x104; four REFILL_WR writes with miss=1 and word_dec 0100, 1000, 0001, 0010; tag_write after the last write; miss_cnt=1.
REQ-040 Stray mem_ack pulses in IDLE and LOOKUP, and cpu_req held high during a refill -> no state change, no extra request accepted, cpu_ready=0 throughout the refill.
REQ-041 Reset asserted after the second refill word -> all outputs at reset values immediately; a following hit completes normally with hit_cnt=1.
REQ-042 hit_cnt preloaded to 0xFFFE by driving 65534 hits, then 2 more hits -> hit_cnt=0xFFFF and stays at 0xFFFF.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache line refill and write sequencing controller
//
// Accepts one CPU load/store at a time, consults the tag-compare result, and on
// a miss fetches the whole line from memory critical-word-first with wrap-around,
// writing each word into the data array before installing the tag. Stores are
// merged into the data array after the refill (or directly on a hit).
//
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   cpu_req, cpu_wr, cpu_addr     CPU request, captured while cpu_ready=1
//   cpu_ready                     controller idle and accepting a request
//   tag_hit                       tag-compare result, consumed in LOOKUP
//   mem_rd, mem_addr              refill read request and word-aligned address
//   mem_ack, mem_data             refill word handshake and data
//   memWrite, miss, word_dec      data-array write enable, source select, word select
//   fill_data                     registered refill word for the data array
//   tag_write                     one-cycle tag/valid install pulse
//   resp_valid                    one-cycle access-complete pulse
//   hit_cnt, miss_cnt             saturating outcome counters

module cache_refill_ctrl #(
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_addr,
    output logic             cpu_ready,
    input  logic             tag_hit,
    output logic             mem_rd,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_data,
    output logic             memWrite,
    output logic             miss,
    output logic [WORDS-1:0] word_dec,
    output logic [31:0]      fill_data,
    output logic             tag_write,
    output logic             resp_valid,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
);

    localparam int OFF_W = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WR,
        TAG_WR,
        CPU_WR,
        DONE
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic              capWr;
    logic [31:2]       capAddr;
    logic [OFF_W-1:0]  fillCnt;
    logic [OFF_W:0]    wordsDone;

    // Byte-lane bits of the CPU address play no part in line refill.
    logic unusedAddrBits;
    assign unusedAddrBits = ^cpu_addr[1:0];

    // Line base from the captured request, word index from the fill counter.
    // Both registers reset to zero, so mem_addr reads zero out of reset.
    assign mem_addr = {capAddr[31:OFF_W+2], fillCnt, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capWr     <= 1'b0;
            capAddr   <= '0;
            fillCnt   <= '0;
            wordsDone <= '0;
            fill_data <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        capWr   <= cpu_wr;
                        capAddr <= cpu_addr[31:2];
                    end
                end
                LOOKUP: begin
                    if (tag_hit) begin
                        if (hit_cnt != 16'hFFFF) begin
                            hit_cnt <= hit_cnt + 16'd1;
                        end
                    end else begin
                        if (miss_cnt != 16'hFFFF) begin
                            miss_cnt <= miss_cnt + 16'd1;
                        end
                        // Start the refill at the word the CPU asked for.
                        fillCnt   <= capAddr[OFF_W+1:2];
                        wordsDone <= '0;
                    end
                end
                REFILL_REQ: begin
                    if (mem_ack) begin
                        fill_data <= mem_data;
                    end
                end
                REFILL_WR: begin
                    // WORDS is a power of two, so natural overflow is the wrap.
                    fillCnt   <= fillCnt + 1'b1;
                    wordsDone <= wordsDone + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        stateNext  = state;
        cpu_ready  = 1'b0;
        mem_rd     = 1'b0;
        memWrite   = 1'b0;
        miss       = 1'b0;
        word_dec   = '0;
        tag_write  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                if (tag_hit) begin
                    stateNext = capWr ? CPU_WR : DONE;
                end else begin
                    stateNext = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    stateNext = REFILL_WR;
                end
            end
            REFILL_WR: begin
                memWrite          = 1'b1;
                miss              = 1'b1;
                word_dec[fillCnt] = 1'b1;
                // wordsDone still counts the words before this write.
                if (wordsDone == (OFF_W+1)'(WORDS - 1)) begin
                    stateNext = TAG_WR;
                end else begin
                    stateNext = REFILL_REQ;
                end
            end
            TAG_WR: begin
                tag_write = 1'b1;
                stateNext = capWr ? CPU_WR : DONE;
            end
            CPU_WR: begin
                memWrite                     = 1'b1;
                word_dec[capAddr[OFF_W+1:2]] = 1'b1;
                stateNext                    = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                stateNext  = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int WORDS = 4;

    logic             clk;
    logic             reset;
    logic             cpu_req;
    logic             cpu_wr;
    logic [31:0]      cpu_addr;
    logic             cpu_ready;
    logic             tag_hit;
    logic             mem_rd;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_data;
    logic             memWrite;
    logic             miss;
    logic [WORDS-1:0] word_dec;
    logic [31:0]      fill_data;
    logic             tag_write;
    logic             resp_valid;
    logic [15:0]      hit_cnt;
    logic [15:0]      miss_cnt;

    int checks = 0;
    int errors = 0;
    int modelHits = 0;
    int modelMisses = 0;

    cache_refill_ctrl #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .tag_hit    (tag_hit),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .memWrite   (memWrite),
        .miss       (miss),
        .word_dec   (word_dec),
        .fill_data  (fill_data),
        .tag_write  (tag_write),
        .resp_valid (resp_valid),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetOuts(input string pfx);
        chk({pfx, "_cpu_ready"},  32'(cpu_ready),  32'd1);
        chk({pfx, "_mem_rd"},     32'(mem_rd),     32'd0);
        chk({pfx, "_memWrite"},   32'(memWrite),   32'd0);
        chk({pfx, "_miss"},       32'(miss),       32'd0);
        chk({pfx, "_tag_write"},  32'(tag_write),  32'd0);
        chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({pfx, "_word_dec"},   32'(word_dec),   32'd0);
        chk({pfx, "_fill_data"},  fill_data,       32'd0);
        chk({pfx, "_mem_addr"},   mem_addr,        32'd0);
        chk({pfx, "_hit_cnt"},    32'(hit_cnt),    32'd0);
        chk({pfx, "_miss_cnt"},   32'(miss_cnt),   32'd0);
    endtask

    // Idle cycles, optionally with stray mem_ack pulses that must be ignored.
    task automatic idleGap(input int n, input bit ack);
        for (int i = 0; i < n; i++) begin
            cpu_req = 1'b0;
            mem_ack = ack;
            mem_data = $urandom;
            chk("idle_cpu_ready", 32'(cpu_ready), 32'd1);
            chk("idle_mem_rd", 32'(mem_rd), 32'd0);
            chk("idle_memWrite", 32'(memWrite), 32'd0);
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    // One CPU access, called and returning at a falling edge with the DUT idle.
    // waitSel < 0 picks a random ack delay per word; abortAt > 0 pulses reset
    // right after that many refill writes.
    task automatic runTxn(input logic [31:0] addr, input bit wr, input bit hit,
                          input int waitSel, input bit noisy, input int abortAt);
        int          waits[WORDS];
        int          off, lat, cyc, wIdx, waitCnt, nWr, nTag, ew, w, expWrites;
        logic [31:0] base, d, expD;
        int          expWord[$];
        bit          expMiss[$];
        logic [31:0] sent[$];
        bit          done, em;

        off  = int'((addr >> 2) % WORDS);
        base = addr - (addr % (WORDS * 4));
        lat  = hit ? 2 : 3;
        for (int i = 0; i < WORDS; i++) waits[i] = 0;
        if (!hit) begin
            for (int i = 0; i < WORDS; i++) begin
                waits[i] = (waitSel < 0) ? int'($urandom_range(3, 0)) : waitSel;
                lat += waits[i] + 2;
                expWord.push_back((off + i) % WORDS);
                expMiss.push_back(1'b1);
            end
            if (modelMisses < 65535) modelMisses++;
        end else if (modelHits < 65535) begin
            modelHits++;
        end
        if (wr) begin
            lat += 1;
            expWord.push_back(off);
            expMiss.push_back(1'b0);
        end
        expWrites = expWord.size();

        chk("accept_cpu_ready", 32'(cpu_ready), 32'd1);
        cpu_req  = 1'b1;
        cpu_wr   = wr;
        cpu_addr = addr;
        tag_hit  = hit;
        mem_ack  = 1'b0;
        @(negedge clk);
        if (noisy) begin
            cpu_addr = $urandom;
            cpu_wr   = ~wr;
        end else begin
            cpu_req = 1'b0;
        end

        cyc = 1; wIdx = 0; waitCnt = 0; nWr = 0; nTag = 0; done = 1'b0;
        while (!done && cyc <= 500) begin
            chk("busy_cpu_ready", 32'(cpu_ready), 32'd0);
            chk("word_dec_onehot", 32'($countones(word_dec) <= 1), 32'd1);
            if (mem_rd) begin
                chk("mem_addr", mem_addr, base + 32'(((off + wIdx) % WORDS) * 4));
                w = (wIdx < WORDS) ? waits[wIdx] : 0;
                if (waitCnt == w) begin
                    d = $urandom;
                    mem_ack  = 1'b1;
                    mem_data = d;
                    sent.push_back(d);
                    waitCnt = 0;
                    wIdx++;
                end else begin
                    mem_ack  = 1'b0;
                    mem_data = $urandom;
                    waitCnt++;
                end
            end else begin
                mem_ack  = noisy;
                mem_data = $urandom;
            end
            if (memWrite) begin
                if (expWord.size() == 0) begin
                    chk("extra_memWrite", 32'(memWrite), 32'd0);
                end else begin
                    ew = expWord.pop_front();
                    em = expMiss.pop_front();
                    chk("word_dec", 32'(word_dec), 32'd1 << ew);
                    chk("miss_sel", 32'(miss), 32'(em));
                    if (em) begin
                        expD = (sent.size() > 0) ? sent.pop_front() : 32'hDEAD_BEEF;
                        chk("fill_data", fill_data, expD);
                    end
                end
                nWr++;
                if (abortAt > 0 && nWr == abortAt) begin
                    #2 reset = 1'b0;
                    #1 checkResetOuts("abort");
                    cpu_req = 1'b0;
                    mem_ack = 1'b0;
                    modelHits = 0;
                    modelMisses = 0;
                    @(negedge clk);
                    reset = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        chk("post_abort_memWrite", 32'(memWrite), 32'd0);
                        chk("post_abort_tag_write", 32'(tag_write), 32'd0);
                        chk("post_abort_cpu_ready", 32'(cpu_ready), 32'd1);
                    end
                    return;
                end
            end
            if (tag_write) begin
                nTag++;
                chk("tag_after_last_write", 32'(nWr), 32'(WORDS));
            end
            if (resp_valid) begin
                done = 1'b1;
                chk("latency", 32'(cyc), 32'(lat));
                cpu_req = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
        chk("resp_seen", 32'(done), 32'd1);
        chk("write_count", 32'(nWr), 32'(expWrites));
        chk("tag_count", 32'(nTag), hit ? 32'd0 : 32'd1);
        chk("hit_cnt", 32'(hit_cnt), 32'(modelHits));
        chk("miss_cnt", 32'(miss_cnt), 32'(modelMisses));
    endtask

    initial begin
        reset    = 1'b0;
        cpu_req  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = '0;
        tag_hit  = 1'b0;
        mem_ack  = 1'b0;
        mem_data = '0;
        repeat (2) @(negedge clk);
        checkResetOuts("reset");
        reset = 1'b1;
        @(negedge clk);

        idleGap(2, 1'b1);
        runTxn(32'h0000_0100, 1'b0, 1'b1, 0, 1'b0, 0);
        runTxn(32'h0000_010C, 1'b1, 1'b1, 0, 1'b0, 0);
        runTxn(32'h0000_0108, 1'b0, 1'b0, 3, 1'b0, 0);
        runTxn(32'h0000_02F4, 1'b1, 1'b0, 1, 1'b1, 0);
        runTxn(32'h0000_0330, 1'b0, 1'b0, 0, 1'b1, 0);

        for (int t = 0; t < 30; t++) begin
            idleGap(int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
            runTxn($urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   -1, 1'($urandom_range(1, 0)), 0);
        end

        runTxn(32'h0000_0208, 1'b0, 1'b0, 1, 1'b0, 2);
        runTxn(32'h0000_0104, 1'b0, 1'b1, 0, 1'b0, 0);
        chk("hit_after_reset", 32'(hit_cnt), 32'd1);

        // Preload the hit counter to one below saturation.
        force dut.hit_cnt = 16'hFFFE;
        #1 release dut.hit_cnt;
        modelHits = 65534;
        chk("hit_cnt_preload", 32'(hit_cnt), 32'h0000_FFFE);
        for (int t = 0; t < 3; t++) begin
            runTxn($urandom, 1'($urandom_range(1, 0)), 1'b1, 0, 1'b0, 0);
        end
        chk("hit_cnt_saturated", 32'(hit_cnt), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
